// File: rtl/fibonacci_bcd_core.sv
// BCD-in / BCD-out Fibonacci engine: serial BCD->binary, iterative F(n) with
// saturation at 10^OUT_DIGITS, then double-dabble back to BCD.
module fib_dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module fibonacci_bcd_core #(
  parameter int IN_DIGITS  = 2,
  parameter int OUT_DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [4*IN_DIGITS-1:0]  iterations_bcd_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic [4*OUT_DIGITS-1:0] result_bcd_o,
  output logic                    overflow_o,
  output logic                    error_o
);
  localparam int LIMIT = 10**OUT_DIGITS;
  localparam int BIN_W = $clog2(LIMIT);
  localparam int N_W   = $clog2(10**IN_DIGITS);
  localparam int CW    = (N_W > $clog2(BIN_W)) ? N_W : $clog2(BIN_W);

  typedef enum logic [2:0] {IDLE, BCD2BIN, FIB, BIN2BCD, DONE} state_t;
  state_t state_q, state_d;

  logic [4*IN_DIGITS-1:0]  n_q;
  logic [N_W-1:0]          acc_q, acc_nx;
  logic                    bad_q, bad_nx;
  logic [CW-1:0]           cnt_q;
  logic [BIN_W:0]          t0_q, t1_q;
  logic [BIN_W-1:0]        bin_q;
  logic [4*OUT_DIGITS-1:0] bcd_q, bcd_nx, adj_w;
  logic [4*OUT_DIGITS-1:0] result_q;
  logic                    ovf_q, err_q;
  logic [3:0]              digit;
  logic                    last, ovf_hit;

  assign digit   = n_q[4*IN_DIGITS-1 -: 4];
  assign acc_nx  = acc_q * N_W'(10) + N_W'(digit);
  assign bad_nx  = bad_q | (digit > 4'd9);
  assign last    = (cnt_q == '0);
  assign ovf_hit = (t1_q >= (BIN_W+1)'(LIMIT));

  for (genvar g = 0; g < OUT_DIGITS; g++) begin : g_dig
    fib_dabble_digit u_dig (.d(bcd_q[4*g +: 4]), .q(adj_w[4*g +: 4]));
  end
  assign bcd_nx = {adj_w[4*OUT_DIGITS-2:0], bin_q[BIN_W-1]};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A flagged operand still passes through FIB, which leaves on its first cycle
  // without iterating.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BCD2BIN;
      BCD2BIN: if (last) state_d = FIB;
      FIB: begin
        if (bad_q)        state_d = DONE;
        else if (last)    state_d = BIN2BCD;
        else if (ovf_hit) state_d = DONE;
      end
      BIN2BCD: if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    done_o  = (state_q == DONE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      n_q <= '0; acc_q <= '0; bad_q <= 1'b0; cnt_q <= '0;
      t0_q <= '0; t1_q <= '0; bin_q <= '0; bcd_q <= '0;
      result_q <= '0; ovf_q <= 1'b0; err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          n_q   <= iterations_bcd_i;
          acc_q <= '0;
          bad_q <= 1'b0;
          cnt_q <= CW'(IN_DIGITS-1);
        end
        BCD2BIN: begin
          n_q   <= n_q << 4;
          acc_q <= acc_nx;
          bad_q <= bad_nx;
          cnt_q <= last ? CW'(acc_nx) : cnt_q - 1'b1;
          if (last) begin
            t0_q <= '0;
            t1_q <= (BIN_W+1)'(1);
          end
        end
        FIB: begin
          if (bad_q) begin
            result_q <= '0; ovf_q <= 1'b0; err_q <= 1'b1;
          end else if (last) begin
            bin_q <= t0_q[BIN_W-1:0];
            bcd_q <= '0;
            cnt_q <= CW'(BIN_W-1);
          end else if (ovf_hit) begin
            result_q <= {OUT_DIGITS{4'h9}}; ovf_q <= 1'b1; err_q <= 1'b0;
          end else begin
            t0_q  <= t1_q;
            t1_q  <= t0_q + t1_q;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BIN2BCD: begin
          bin_q <= bin_q << 1;
          bcd_q <= bcd_nx;
          cnt_q <= cnt_q - 1'b1;
          if (last) begin
            result_q <= bcd_nx; ovf_q <= 1'b0; err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_bcd_o = result_q;
  assign overflow_o   = ovf_q;
  assign error_o      = err_q;
endmodule

// File: tb/tb_fibonacci_bcd_core.sv
// Self-checking bench: directed corner cases plus random operands against an
// arithmetic Fibonacci model.
module tb_fibonacci_bcd_core;
  localparam int ID  = 2;
  localparam int OD  = 4;
  localparam int BW  = 14;
  localparam int LIM = 10000;

  logic            clk_i = 1'b0;
  logic            reset_i, start_i;
  logic [4*ID-1:0] iterations_bcd_i;
  logic            ready_o, done_o, overflow_o, error_o;
  logic [4*OD-1:0] result_bcd_o;

  int checks = 0, errors = 0;
  logic [4*OD-1:0] last_res;
  logic            last_ovf, last_err;

  fibonacci_bcd_core #(.IN_DIGITS(ID), .OUT_DIGITS(OD)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .iterations_bcd_i(iterations_bcd_i), .ready_o(ready_o), .done_o(done_o),
    .result_bcd_o(result_bcd_o), .overflow_o(overflow_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Latency counts clock edges, the start-sampling edge being edge 1.
  task automatic model(input logic [4*ID-1:0] nb, output logic [4*OD-1:0] res,
                       output logic ovf, output logic err, output int lat);
    int n, k;
    longint a, b, t;
    err = 1'b0;
    for (int d = 0; d < ID; d++) if (nb[4*d +: 4] > 4'd9) err = 1'b1;
    res = '0; ovf = 1'b0;
    if (err) begin
      lat = 1 + ID + 1;
    end else begin
      n = 0;
      for (int d = ID-1; d >= 0; d--) n = n*10 + int'(nb[4*d +: 4]);
      a = 0; b = 1; k = -1;
      for (int i = 0; i < n; i++) begin
        if (b >= LIM) begin k = i; break; end
        t = a + b; a = b; b = t;
      end
      if (k >= 0) begin
        ovf = 1'b1;
        for (int d = 0; d < OD; d++) res[4*d +: 4] = 4'h9;
        lat = 1 + ID + k + 1;
      end else begin
        t = a;
        for (int d = 0; d < OD; d++) begin
          res[4*d +: 4] = 4'(t % 10);
          t = t / 10;
        end
        lat = 1 + ID + n + 1 + BW;
      end
    end
  endtask

  task automatic run_op(input logic [4*ID-1:0] nb, input bit inject, input bit poke);
    logic [4*OD-1:0] res;
    logic ovf, err;
    int lat, cyc;
    bit stable;
    model(nb, res, ovf, err, lat);
    iterations_bcd_i = nb;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    iterations_bcd_i = 8'($urandom);
    cyc = 1;
    stable = 1'b1;
    while (!done_o && cyc < 200) begin
      if (ready_o || result_bcd_o !== last_res || overflow_o !== last_ovf ||
          error_o !== last_err) stable = 1'b0;
      if (inject && cyc == 6) begin
        start_i = 1'b1;
        iterations_bcd_i = 8'h05;
      end else start_i = 1'b0;
      @(posedge clk_i); #1;
      cyc++;
    end
    chk($sformatf("latency n=%0h", nb), cyc, lat);
    chk("done_high", done_o, 1);
    chk($sformatf("result n=%0h", nb), result_bcd_o, res);
    chk("overflow", overflow_o, ovf);
    chk("error", error_o, err);
    if (ovf) chk("ovf_within_40", (cyc <= 40), 1);
    last_res = res; last_ovf = ovf; last_err = err;
    start_i = poke;
    if (poke) iterations_bcd_i = 8'($urandom);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("done_pulse_one_cycle", done_o, 0);
    chk("ready_after_done", ready_o, 1);
    chk("hold_while_busy", stable, 1);
  endtask

  initial begin
    logic [7:0] nb;
    int v;
    reset_i = 1'b1; start_i = 1'b0; iterations_bcd_i = '0;
    #2 reset_i = 1'b0;
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_bcd_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_err", error_o, 0);
    last_res = '0; last_ovf = 1'b0; last_err = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i); #1;

    run_op(8'h00, 0, 0);
    run_op(8'h10, 0, 0);
    run_op(8'h20, 0, 1);
    run_op(8'h21, 0, 0);
    run_op(8'h99, 0, 0);
    run_op(8'h1A, 0, 0);
    run_op(8'h20, 1, 0);
    run_op(8'h05, 0, 0);

    // Reset in the middle of FIB for n=15.
    iterations_bcd_i = 8'h15; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #3 reset_i = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_done", done_o, 0);
    chk("midrst_result", result_bcd_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_err", error_o, 0);
    last_res = '0; last_ovf = 1'b0; last_err = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("no_done_in_reset", done_o, 0);
    end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    run_op(8'h07, 0, 0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(3) == 0) nb = 8'($urandom);
      else begin
        v = $urandom_range(99);
        nb = {4'(v / 10), 4'(v % 10)};
      end
      run_op(nb, ($urandom_range(3) == 0), ($urandom_range(2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
